// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V opcode and M-extension divide match constants
package riscv_pkg;
   localparam logic [4:0] OPC_OP    = 5'b01100;
   localparam logic [4:0] OPC_OP32  = 5'b01110;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   // W variants reuse the same func3 codes under OPC_OP32
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;
endpackage

// File: rtl/riscv_div.sv
// riscv_div: iterative restoring divider for DIV/DIVU/REM/REMU (+W forms on RV64)
module riscv_div
   import riscv_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int INSTR_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  div_stall,
   input  logic                  id_bubble,
   input  logic [INSTR_SIZE-1:0] id_instr,
   input  logic [XLEN-1:0]       opA,
   input  logic [XLEN-1:0]       opB,
   output logic                  div_bubble,
   output logic [XLEN-1:0]       div_r
);
   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_FINISH} state_t;
   localparam int CW = $clog2(XLEN);

   function automatic logic [XLEN-1:0] twos(input logic [XLEN-1:0] v);
      return ~v + 1'b1;
   endfunction

   function automatic logic [XLEN-1:0] abs(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? twos(v) : v;
   endfunction

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return XLEN'($signed(v));
   endfunction

   function automatic logic [XLEN-1:0] fix(input logic [XLEN-1:0] v, input logic w);
      return w ? sext32(v[31:0]) : v;
   endfunction

   // Shift in the next dividend bit and subtract in XLEN+1 bits; a borrow restores.
   function automatic logic [2*XLEN-1:0] step(input logic [XLEN-1:0] rem, input logic [XLEN-1:0] quo,
                                              input logic [XLEN-1:0] dvs);
      logic [XLEN:0] sh, df;
      sh = {rem, quo[XLEN-1]};
      df = sh - {1'b0, dvs};
      return df[XLEN] ? {sh[XLEN-1:0], quo[XLEN-2:0], 1'b0} : {df[XLEN-1:0], quo[XLEN-2:0], 1'b1};
   endfunction

   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, r_q, r_d;
   logic nq_q, nq_d, nr_q, nr_d, sel_q, sel_d, w_q, w_d, stall_q, stall_d, bubble_q, bubble_d;
   logic [6:0] f7;
   logic [2:0] f3;
   logic [4:0] opc;
   logic is_w, acc, sgn, is_rem, dz, ovf;
   logic [XLEN-1:0] a, b, min_v, quo_s, rem_s, q_f, r_f;
   logic unused_ok;

   assign f7 = id_instr[31:25];
   assign f3 = id_instr[14:12];
   assign opc = id_instr[6:2];
   assign unused_ok = ^{id_instr[24:15], id_instr[11:7], id_instr[1:0]};

   always_comb begin
      is_w = (XLEN == 64) && opc == OPC_OP32;
      acc = !id_bubble && f7 == F7_MULDIV && (opc == OPC_OP || is_w) && f3[2];
      sgn = !f3[0];
      is_rem = f3[1];
      a = is_w ? (sgn ? sext32(opA[31:0]) : XLEN'(opA[31:0])) : opA;
      b = is_w ? (sgn ? sext32(opB[31:0]) : XLEN'(opB[31:0])) : opB;
      min_v = is_w ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
      dz = b == '0;
      ovf = sgn && a == min_v && b == '1;
      {rem_s, quo_s} = step(rem_q, quo_q, dvs_q);
      q_f = nq_q ? twos(quo_q) : quo_q;
      r_f = nr_q ? twos(rem_q) : rem_q;
      state_d = state_q;
      cnt_d = cnt_q;
      quo_d = quo_q;
      rem_d = rem_q;
      dvs_d = dvs_q;
      nq_d = nq_q;
      nr_d = nr_q;
      sel_d = sel_q;
      w_d = w_q;
      stall_d = stall_q;
      bubble_d = 1'b1;
      r_d = r_q;
      unique case (state_q)
         ST_IDLE: if (acc) begin
            if (dz || ovf) begin
               r_d = fix(dz ? (is_rem ? a : '1) : (is_rem ? '0 : a), is_w);
               bubble_d = 1'b0;
            end else begin
               quo_d = sgn ? abs(a) : a;
               dvs_d = sgn ? abs(b) : b;
               rem_d = '0;
               nq_d = sgn && (a[XLEN-1] ^ b[XLEN-1]);
               nr_d = sgn && a[XLEN-1];
               sel_d = is_rem;
               w_d = is_w;
               cnt_d = CW'(XLEN-1);
               stall_d = 1'b1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            quo_d = quo_s;
            rem_d = rem_s;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == '0 ? ST_FINISH : ST_BUSY;
         end
         ST_FINISH: begin
            r_d = fix(sel_q ? r_f : q_f, w_q);
            bubble_d = 1'b0;
            stall_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q <= '0;
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
         nq_q <= 1'b0;
         nr_q <= 1'b0;
         sel_q <= 1'b0;
         w_q <= 1'b0;
         stall_q <= 1'b0;
         bubble_q <= 1'b1;
         r_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         quo_q <= quo_d;
         rem_q <= rem_d;
         dvs_q <= dvs_d;
         nq_q <= nq_d;
         nr_q <= nr_d;
         sel_q <= sel_d;
         w_q <= w_d;
         stall_q <= stall_d;
         bubble_q <= bubble_d;
         r_q <= r_d;
      end
   end

   assign div_stall = stall_q;
   assign div_bubble = bubble_q;
   assign div_r = r_q;
endmodule

// File: tb/tb_riscv_div.sv
// tb_riscv_div: directed scoreboard bench for riscv_div at XLEN=32
module tb_riscv_div;
   typedef struct {
      string       name;
      logic [31:0] v;
   } exp_t;

   logic clk = 1'b0, rst = 1'b1, id_bubble = 1'b1, div_stall, div_bubble;
   logic [31:0] id_instr = '0, opA = '0, opB = '0, div_r;
   exp_t exp_q[$];
   int errors = 0, checks = 0;

   riscv_div #(.XLEN(32), .INSTR_SIZE(32)) dut (
      .clk(clk), .rst(rst), .div_stall(div_stall), .id_bubble(id_bubble), .id_instr(id_instr),
      .opA(opA), .opB(opB), .div_bubble(div_bubble), .div_r(div_r)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   always @(negedge clk) begin
      if (div_bubble === 1'b0) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: got %h expected no result", div_r);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (div_r !== e.v) begin
               errors++;
               $display("FAIL %s: got %h expected %h", e.name, div_r, e.v);
            end
         end
      end
   end

   task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] want, input int want_stall);
      int st, n;
      @(negedge clk);
      id_instr = enc(7'b0000001, f3);
      opA = a;
      opB = b;
      id_bubble = 1'b0;
      exp_q.push_back('{name, want});
      @(negedge clk);
      id_bubble = 1'b1;
      id_instr = '0;
      st = 0;
      for (n = 0; n < 100 && div_bubble; n++) begin
         st += int'(div_stall);
         @(negedge clk);
      end
      chk({name, "_done"}, 32'(n < 100), 32'd1);
      chk({name, "_stall"}, st, want_stall);
   endtask

   task automatic quiet(input string name, input logic [31:0] ins, input logic bub);
      @(negedge clk);
      id_instr = ins;
      opA = 32'd10;
      opB = 32'd2;
      id_bubble = bub;
      @(negedge clk);
      id_bubble = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk({name, "_stall"}, 32'(div_stall), 32'd0);
         chk({name, "_bubble"}, 32'(div_bubble), 32'd1);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_div_r", div_r, 32'd0);
      chk("rst_bubble", 32'(div_bubble), 32'd1);
      chk("rst_stall", 32'(div_stall), 32'd0);
      rst = 1'b0;
      run("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
      run("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
      run("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
      run("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
      run("div_7_m2", 3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
      run("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run("remu_5_0", 3'b111, 32'd5, 32'd0, 32'd5, 0);
      run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run("divu_big", 3'b101, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 33);
      quiet("div_id_bubble", enc(7'b0000001, 3'b100), 1'b1);
      quiet("add_instr", enc(7'b0000000, 3'b000), 1'b0);
      @(negedge clk);
      id_instr = enc(7'b0000001, 3'b101);
      opA = 32'd100;
      opB = 32'd7;
      id_bubble = 1'b0;
      @(negedge clk);
      id_bubble = 1'b1;
      repeat (9) @(negedge clk);
      chk("busy10_stall", 32'(div_stall), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_stall", 32'(div_stall), 32'd0);
      chk("midrst_bubble", 32'(div_bubble), 32'd1);
      repeat (40) @(negedge clk);
      chk("midrst_quiet", 32'(div_stall), 32'd0);
      run("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 33);
      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/riscv_div.md
RISCV_DIV -- requirements
Module: riscv_div

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values are 32 and 64.
REQ-002 SHALL have parameter INSTR_SIZE, default 32, instruction width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port div_stall, output, 1, request to stall the pipeline while a division iterates.
REQ-006 SHALL have port id_bubble, input, 1, high when id_instr is not a valid instruction.
REQ-007 SHALL have port id_instr, input, INSTR_SIZE, instruction from ID; fields are func7[31:25], func3[14:12], opcode[6:2].
REQ-008 SHALL have ports opA and opB, input, XLEN each, dividend and divisor from ID.
REQ-009 SHALL have port div_bubble, output, 1, low for exactly one cycle when div_r holds a new result.
REQ-010 SHALL have port div_r, output, XLEN, registered result to WB.

Function
REQ-011 SHALL decode DIV, DIVU, REM and REMU; DIVW, DIVUW, REMW and REMUW SHALL be decoded only when XLEN=64, with operands and results taken from bits [31:0] and sign-extended to XLEN.
REQ-012 SHALL accept an instruction on a rising edge E0 only when state=ST_IDLE, id_bubble=0 and the instruction is a divide/remainder; otherwise it SHALL take no action in ST_IDLE.
REQ-013 SHALL default div_bubble to 1 on every edge unless a result is being delivered on that edge.
REQ-014 SHALL resolve special cases at E0 with no stall, registering div_r and driving div_bubble=0 for the following cycle.
- Divide by zero: quotient is all-ones; remainder is the dividend.
- Signed overflow (most-negative / -1): quotient is the dividend; remainder is 0.
REQ-015 SHALL, for a normal accept at E0, register the absolute values of the operands (unsigned ops pass unchanged), record the quotient and remainder signs, set cnt=XLEN-1, enter ST_BUSY and set div_stall=1.
REQ-016 SHALL produce one quotient bit per edge in ST_BUSY using a restoring shift/subtract, over a remainder width of XLEN+1 bits.
REQ-017 SHALL go from ST_BUSY to ST_FINISH on the edge where cnt=0, and otherwise decrement cnt.
REQ-018 SHALL, in ST_FINISH on edge E(XLEN+1), do all of the following.
- Negate the quotient if the operand signs differ for signed ops.
- Negate the remainder if the dividend is negative for signed ops.
- Register the selected value to div_r.
- Set div_bubble=0 and div_stall=0, and return to ST_IDLE.
REQ-019 SHALL keep div_stall high for exactly XLEN+1 cycles per normal division.
REQ-020 SHALL ignore id_instr, opA, opB and id_bubble in ST_BUSY and ST_FINISH.
REQ-021 SHALL hold div_r unchanged between results.
REQ-022 SHALL accept a new division on the edge immediately after ST_FINISH returns to ST_IDLE.

Reset
REQ-023 SHALL, when rst=1 at an edge, set state=ST_IDLE, cnt=0, div_stall=0, div_bubble=1 and div_r=0.
REQ-024 SHALL discard any in-flight division on reset, so that no result is delivered and div_bubble stays 1.
REQ-025 SHALL give reset priority over acceptance in the same cycle.

Structure
REQ-026 SHALL take the DIV/DIVU/REM/REMU and W-variant instruction match constants from the shared riscv_pkg.
REQ-027 SHALL keep the state enum (ST_IDLE, ST_BUSY, ST_FINISH) and the helper functions (twos, abs, sext32) local to the module.
REQ-028 SHALL be a single module with no sub-module; the restoring step is a local function.

Verification (XLEN=32)
REQ-029 SHALL check DIVU 100/7: div_stall high for 33 cycles, then div_r=14 with div_bubble=0 for one cycle; REMU 100%7 SHALL give 2.
REQ-030 SHALL check signed ops: DIV -7/2 gives 0xFFFFFFFD; REM -7%2 gives 0xFFFFFFFF; DIV 7/-2 gives 0xFFFFFFFD; REM 7%-2 gives 1.
REQ-031 SHALL check divide by zero: DIV 5/0 gives 0xFFFFFFFF and REMU 5%0 gives 5, each delivered the cycle after E0 with div_stall never asserted.
REQ-032 SHALL check overflow: DIV 0x80000000/0xFFFFFFFF gives 0x80000000 and REM gives 0, with no stall.
REQ-033 SHALL check that a DIV instruction presented with id_bubble=1, or a non-divide instruction, produces no response (div_bubble=1, div_stall=0).
REQ-034 SHALL check reset mid-operation: rst=1 in the 10th ST_BUSY cycle gives div_stall=0 and div_bubble=1 next cycle with no result; a following DIVU 9/3 gives 3 after 33 stall cycles.
